// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one difference bit per cycle, LSB first,
// result = {final borrow, a - b}.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | one bit per cycle, SIZE cycles
// DONE  | one-cycle completion pulse, result already loaded
module serial_sub #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE:0]   result
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [SIZE-1:0] op_a, op_b, diff, diff_shift;
  logic [CW-1:0]   cnt;
  logic            br, br_nx, d, last;

  assign d     = op_a[0] ^ op_b[0] ^ br;
  assign br_nx = (~op_a[0] & op_b[0]) | (~(op_a[0] ^ op_b[0]) & br);
  assign last  = (cnt == CW'(SIZE - 1));

  // New bit enters at the MSB so bit i ends up in position i after SIZE shifts.
  if (SIZE == 1) begin : g_one
    assign diff_shift = d;
  end else begin : g_multi
    assign diff_shift = {d, diff[SIZE-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      diff   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a <= a;
          op_b <= b;
          diff <= '0;
          cnt  <= '0;
          br   <= 1'b0;
        end
        RUN: begin
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          br   <= br_nx;
          diff <= diff_shift;
          if (last) result <= {br_nx, diff_shift};
          else      cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at SIZE = 2, 8 and 1 sharing one clock and reset.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       st2, busy2, done2;
  logic [1:0] a2, b2;
  logic [2:0] res2;
  logic       st8, busy8, done8;
  logic [7:0] a8, b8;
  logic [8:0] res8;
  logic       st1, busy1, done1;
  logic [0:0] a1, b1;
  logic [1:0] res1;

  int n_assert = 0;
  int n_fail   = 0;

  serial_sub #(.SIZE(2)) u_s2 (.clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2),
                              .busy(busy2), .done(done2), .result(res2));
  serial_sub #(.SIZE(8)) u_s8 (.clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
                              .busy(busy8), .done(done8), .result(res8));
  serial_sub #(.SIZE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
                              .busy(busy1), .done(done1), .result(res1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] av, input logic [7:0] bv);
    case (sel)
      0: begin st2 = s; a2 = av[1:0]; b2 = bv[1:0]; end
      1: begin st8 = s; a8 = av;      b8 = bv;      end
      default: begin st1 = s; a1 = av[0:0]; b1 = bv[0:0]; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done2 : (sel == 1) ? done8 : done1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy2 : (sel == 1) ? busy8 : busy1;
  endfunction

  function automatic logic [8:0] get_res(input int sel);
    return (sel == 0) ? {6'b0, res2} : (sel == 1) ? res8 : {7'b0, res1};
  endfunction

  // Called at a negedge; start is accepted on the following posedge. Operands are
  // inverted right after capture to show they no longer matter.
  task automatic run(input int sel, input int size, input logic [7:0] av, input logic [7:0] bv,
                     input logic [8:0] exp, input string tag);
    int k, bc;
    logic stable;
    logic [8:0] r0;
    drive(sel, 1'b1, av, bv);
    r0 = get_res(sel);
    stable = 1'b1;
    k = 0;
    bc = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) drive(sel, 1'b0, ~av, ~bv);
      if (get_busy(sel)) bc++;
      if (!get_done(sel) && get_res(sel) !== r0) stable = 1'b0;
    end while (!get_done(sel) && k < 40);
    chk({tag, " latency"}, k, size + 1);
    chk({tag, " busy_cycles"}, bc, size + 1);
    chk({tag, " result_stable"}, {31'b0, stable}, 32'd1);
    chk({tag, " done"}, {31'b0, get_done(sel)}, 32'd1);
    chk({tag, " result"}, {23'b0, get_res(sel)}, {23'b0, exp});
    @(negedge clk);
    chk({tag, " done_low"}, {31'b0, get_done(sel)}, 32'd0);
    chk({tag, " idle"}, {31'b0, get_busy(sel)}, 32'd0);
  endtask

  initial begin
    int k, nd;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h0, 8'h0);
    drive(1, 1'b0, 8'h0, 8'h0);
    drive(2, 1'b0, 8'h0, 8'h0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst busy", {31'b0, get_busy(s)}, 32'd0);
      chk("rst done", {31'b0, get_done(s)}, 32'd0);
      chk("rst result", {23'b0, get_res(s)}, 32'd0);
    end
    rst_n = 1'b1;

    run(1, 8, 8'h00, 8'h01, 9'h1FF, "s8 0-1");
    run(1, 8, 8'hA5, 8'hA5, 9'h000, "s8 a5-a5");
    run(1, 8, 8'h3C, 8'h5A, 9'h1E2, "s8 3c-5a");
    run(1, 8, 8'hFF, 8'h01, 9'h0FE, "s8 ff-1");

    run(0, 2, 8'h3, 8'h1, 9'b010, "s2 3-1");
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [8:0] e;
        e = {6'b0, (i < j), 2'(i - j)};
        run(0, 2, 8'(i), 8'(j), e, "s2 exh");
      end
    end

    run(2, 1, 8'h0, 8'h1, 9'b11, "s1 0-1");
    run(2, 1, 8'h1, 8'h0, 9'b01, "s1 1-0");
    run(2, 1, 8'h1, 8'h1, 9'b00, "s1 1-1");

    // start held high: second operation picks up whatever is present at its own accept edge
    drive(1, 1'b1, 8'h10, 8'h03);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) drive(1, 1'b1, 8'h55, 8'h22);
    end while (!done8 && k < 40);
    chk("held first latency", k, 9);
    chk("held first result", {23'b0, res8}, 32'h00D);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done8 && k < 40);
    chk("held period", k, 10);
    chk("held second result", {23'b0, res8}, 32'h033);
    drive(1, 1'b0, 8'h0, 8'h0);
    @(negedge clk);
    chk("held idle", {31'b0, busy8}, 32'd0);

    // reset during bit 4 of an operation
    drive(1, 1'b1, 8'h40, 8'h01);
    @(negedge clk);
    drive(1, 1'b0, 8'h0, 8'h0);
    repeat (4) @(negedge clk);
    chk("pre-rst busy", {31'b0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst busy", {31'b0, busy8}, 32'd0);
    chk("mid-rst done", {31'b0, done8}, 32'd0);
    chk("mid-rst result", {23'b0, res8}, 32'd0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("mid-rst no done", nd, 0);
    rst_n = 1'b1;
    run(1, 8, 8'h40, 8'h01, 9'h03F, "s8 after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL provide parameter SIZE, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL provide port a  input  SIZE  minuend, captured on an accepted start.
REQ-006 SHALL provide port b  input  SIZE  subtrahend, captured on an accepted start.
REQ-007 SHALL provide port busy  output  1  high while in RUN or DONE state.
REQ-008 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-009 SHALL provide port result  output  SIZE+1  {borrow, difference}; MSB is final borrow.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 SHALL accept start only when state is IDLE and start=1 at a rising edge; capture a, b into shift registers, clear borrow and bit counter, go to RUN.
REQ-012 SHALL ignore start (no capture, no state change) in RUN and DONE.
REQ-013 SHALL process exactly one bit per RUN cycle, LSB first, bit index 0..SIZE-1.
REQ-014 SHALL compute per bit: d = a_i XOR b_i XOR br; br_next = (NOT a_i AND b_i) OR (NOT(a_i XOR b_i) AND br).
REQ-015 SHALL shift d into the difference register MSB-ward so that after SIZE RUN cycles bit i holds d_i.
REQ-016 SHALL leave RUN for DONE on the edge that processes bit SIZE-1 (counter = SIZE-1).
REQ-017 SHALL, on that same edge, load result = {br_next, difference}; result[SIZE-1:0] = (a - b) mod 2^SIZE, result[SIZE] = 1 iff a < b (unsigned).
REQ-018 SHALL assert done=1 for exactly the single cycle the FSM is in DONE, then return to IDLE on the next edge.
REQ-019 SHALL have latency: start accepted at edge N -> done high in the cycle after edge N+SIZE; next start acceptable at edge N+SIZE+2 or later.
REQ-020 SHALL hold result stable from its load until the next completion; result SHALL NOT change during RUN.
REQ-021 SHALL drive busy = 1 in RUN and DONE, 0 in IDLE.
REQ-022 SHALL size the bit counter as clog2(SIZE) bits minimum (1 bit when SIZE=1); no wrap before DONE.
REQ-023 SHALL for SIZE=1 spend exactly one RUN cycle.
REQ-024 SHALL treat operand changes after capture as don't-care (no effect on in-flight operation).

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, busy=0, done=0, result=0, borrow=0, counter=0, operand registers=0, independent of clk.
REQ-026 SHALL abort any in-flight operation on reset assertion with no done pulse and result=0.
REQ-027 SHALL accept a start on the first rising edge after rst_n deasserts.

Verification
REQ-028 SIZE=2, a=2'b11, b=2'b01, start one cycle -> done after 2 RUN cycles, result=3'b010, busy high 3 cycles.
REQ-029 SIZE=2, exhaustive a,b in 0..3 back-to-back starts -> result[1:0]=(a-b) mod 4, result[2]=(a<b), e.g. a=00,b=01 -> 3'b111.
REQ-030 SIZE=8, a=8'h00, b=8'h01 -> result=9'h1FF; a=8'hA5, b=8'hA5 -> result=9'h000; done exactly 9 cycles after start edge.
REQ-031 SIZE=8, start held high continuously, operands toggled during RUN -> only first capture used, one done per 10 cycles, result matches captured operands.
REQ-032 SIZE=8, rst_n pulsed low mid-RUN (bit 4) -> outputs immediately 0, no done pulse, next start completes correctly.
REQ-033 SIZE=1, a=0, b=1 -> done one cycle after RUN, result=2'b11; a=1,b=0 -> 2'b01.
